// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a little-endian byte stream
// (LEN, DATA words, XOR checksum) while holding the core, then releases it.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned DEPTH_WORDS   = 256,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]  word_cnt_q, word_cnt_d;
  logic [CW-1:0]  len_q, len_d;
  logic [23:0]    shift_q, shift_d;
  logic [31:0]    csum_q, csum_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           byte_ready_q, byte_ready_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           core_hold_q, core_hold_d;

  logic           accept_c;
  logic           last_byte_c;
  logic [31:0]    assembled_c;

  assign accept_c    = byte_valid && byte_ready_q;
  assign last_byte_c = (byte_cnt_q == 2'd3);
  assign assembled_c = {byte_in, shift_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    byte_ready_d = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    core_hold_d  = core_hold_q;

    // Shared byte-lane assembly for LEN, DATA and CSUM fields
    if (accept_c) begin
      shift_d    = assembled_c[31:8];
      byte_cnt_d = 2'(byte_cnt_q + 2'd1);
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN: begin
        if (accept_c && last_byte_c) begin
          if (assembled_c == 32'd0 || assembled_c > 32'(DEPTH_WORDS)) begin
            state_d = S_ERR;
          end else begin
            len_d   = CW'(assembled_c);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c && last_byte_c) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + (32'(word_cnt_q) << 2);
          wr_data_d = assembled_c;
        end
      end
      S_WRITE: begin
        csum_d     = csum_q ^ wr_data_q;
        word_cnt_d = CW'(word_cnt_q + CW'(1));
        state_d    = (CW'(word_cnt_q + CW'(1)) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept_c && last_byte_c) begin
          state_d = (assembled_c == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the state being entered; IDLE keeps reset hold value
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    if (state_d != S_IDLE) begin
      core_hold_d = (state_d != S_DONE);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_hold_q  <= core_hold_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven sessions, directed corner cases,
// and randomized frames checked against a simple frame-level model.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, core_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every memory write strobe
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  end

  typedef struct {
    string           name;
    logic [31:0]     len;
    logic [3:0][31:0] w;
    logic [31:0]     csum_flip;
    int              gap_max;
    bit              mid_start;
    bit              exp_done;
    bit              exp_err;
    int              exp_nw;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    repeat ($urandom_range(0, gap_max)) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      check("byte_ready timeout", {31'd0, byte_ready}, 32'd1);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), gap_max);
  endtask

  // Full session from start pulse to final status, then compare writes
  task automatic run_session(input string nm, input logic [31:0] len,
                             input logic [3:0][31:0] w, input logic [31:0] csum_flip,
                             input int gap_max, input bit mid_start,
                             input bit exp_done, input bit exp_err, input int exp_nw);
    logic [31:0] x;
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({nm, " ready after start"}, {31'd0, byte_ready}, 32'd1);
    send_word(len, gap_max);
    if (len >= 1 && len <= DEPTH) begin
      x = 32'd0;
      for (int i = 0; i < int'(len); i++) begin
        send_word(w[i], gap_max);
        x ^= w[i];
        if (mid_start && i == 0) pulse_start();
      end
      send_word(x ^ csum_flip, gap_max);
    end
    tick();
    tick();
    check({nm, " done"},      {31'd0, done},       {31'd0, exp_done});
    check({nm, " error"},     {31'd0, error},      {31'd0, exp_err});
    check({nm, " core_hold"}, {31'd0, core_hold},  {31'd0, !exp_done});
    check({nm, " byte_ready"},{31'd0, byte_ready}, 32'd0);
    check({nm, " write count"}, 32'(got_addr.size()), 32'(exp_nw));
    for (int i = 0; i < exp_nw && i < got_addr.size(); i++) begin
      check({nm, " wr_addr"}, got_addr[i], BASE + 32'(4 * i));
      check({nm, " wr_data"}, got_data[i], w[i]);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " wr_en"},      {31'd0, wr_en},      32'd0);
    check({nm, " wr_addr"},    wr_addr,             BASE);
    check({nm, " wr_data"},    wr_data,             32'd0);
    check({nm, " byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({nm, " done"},       {31'd0, done},       32'd0);
    check({nm, " error"},      {31'd0, error},      32'd0);
    check({nm, " core_hold"},  {31'd0, core_hold},  32'd1);
  endtask

  initial begin
    logic [3:0][31:0] ws;
    logic [3:0][31:0] rw;
    int n;
    logic [31:0] flip;
    bit ok;

    ws = '0;
    ws[0] = 32'h0010_0513;
    ws[1] = 32'h0020_0593;

    vecs[0] = '{"s1 two words", 32'd2, ws, 32'd0, 0, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{"s2 zero len", 32'd0, ws, 32'd0, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[2] = '{"s3 len over depth", 32'd5, ws, 32'd0, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{"s4 bad csum", 32'd2, ws, 32'd1, 0, 1'b0, 1'b0, 1'b1, 2};
    vecs[4] = '{"s5 gaps mid start", 32'd2, ws, 32'd0, 4, 1'b1, 1'b1, 1'b0, 2};
    vecs[5] = '{"huge len", 32'hFFFF_FFFF, ws, 32'd0, 0, 1'b0, 1'b0, 1'b1, 0};
    rw = '0;
    rw[0] = 32'hDEAD_BEEF; rw[1] = 32'h0000_0013; rw[2] = 32'hFFFF_FFFF; rw[3] = 32'h1234_5678;
    vecs[6] = '{"s3 len at depth", 32'd4, rw, 32'd0, 1, 1'b0, 1'b1, 1'b0, 4};
    vecs[7] = '{"one word", 32'd1, rw, 32'd0, 0, 1'b0, 1'b1, 1'b0, 1};

    // Reset state, with a byte offered that must not be taken
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    tick();
    tick();
    check("idle byte_ready", {31'd0, byte_ready}, 32'd0);
    check("idle core_hold", {31'd0, core_hold}, 32'd1);
    byte_valid = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_session(vecs[v].name, vecs[v].len, vecs[v].w, vecs[v].csum_flip,
                  vecs[v].gap_max, vecs[v].mid_start, vecs[v].exp_done,
                  vecs[v].exp_err, vecs[v].exp_nw);
    end

    // wr_en rises the cycle after the 4th data byte and lasts one cycle
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    check("wr timing wr_en", {31'd0, wr_en}, 32'd1);
    check("wr timing ready low", {31'd0, byte_ready}, 32'd0);
    check("wr timing addr", wr_addr, BASE);
    check("wr timing data", wr_data, 32'hCAFE_F00D);
    tick();
    check("wr timing wr_en drop", {31'd0, wr_en}, 32'd0);
    check("wr timing csum ready", {31'd0, byte_ready}, 32'd1);
    send_word(32'hCAFE_F00D, 0);
    check("wr timing done", {31'd0, done}, 32'd1);
    check("wr timing count", 32'(got_addr.size()), 32'd1);

    // Reset in the middle of DATA, then a clean reload
    pulse_start();
    send_word(32'd2, 0);
    send_word(ws[0], 0);
    send_byte(8'h93, 0);
    send_byte(8'h05, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid reset");
    tick();
    rst_n = 1'b1;
    tick();
    run_session("after reset", 32'd2, ws, 32'd0, 0, 1'b0, 1'b1, 1'b0, 2);

    // Randomized frames against a frame-level model
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, DEPTH + 1);
      for (int i = 0; i < 4; i++) rw[i] = $urandom;
      flip = ($urandom_range(0, 3) == 0) ? (32'($urandom) | 32'h1) : 32'd0;
      ok = (n >= 1) && (n <= DEPTH);
      run_session("random", 32'(n), rw, flip, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), ok && (flip == 32'd0),
                  !(ok && (flip == 32'd0)), ok ? n : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
